gsensor_spi_responder: RTL and testbench

- Synthesizable SPI responder that emulates the ADXL345 register interface seen by the accelerometer SPI initiator.
- Lets the arm pipeline (accelerometer → FSM → PWM) run in simulation or on a board without the physical G-sensor.
- Test samples are injected on the sample_* ports and returned through the data registers.
- Supports 4-wire and 3-wire modes, selected by DATA_FORMAT.SPI, as the real part does.

---
 rtl/gsensor_pkg.sv | 66 ++++++
 rtl/spi_input_sync.sv | 47 ++++
 rtl/gsensor_spi_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_gsensor_spi_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_pkg.sv
// ---------------------------------------------------------------------------
// gsensor_pkg
//   Shared definitions for the ADXL345-style SPI responder.
//   - Register addresses of the emulated register map.
//   - Transaction state enum (IDLE, CMD, RDATA, WDATA).
//   - Command byte bit positions and control-register bit positions.
//   - Debug struct that exposes the FSM and conditioned SPI lines.
//   - Address classification helpers shared by the responder.
// ---------------------------------------------------------------------------
package gsensor_pkg;

  // Register map addresses (6-bit address space).
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_RW_LO       = 6'h1D;
  localparam logic [5:0] ADDR_RW_HI       = 6'h2F;
  localparam logic [5:0] ADDR_RO_2B       = 6'h2B;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
  localparam logic [5:0] ADDR_SPARE0      = 6'h38;
  localparam logic [5:0] ADDR_SPARE1      = 6'h39;

  // Command byte layout: R/W | MB | A5..A0.
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_MB_BIT   = 6;
  localparam int CMD_ADDR_MSB = 5;

  // Control bits inside registers.
  localparam int FMT_SPI3_BIT       = 6;  // DATA_FORMAT.SPI: 1 = 3-wire
  localparam int INT_DATA_READY_BIT = 7;  // INT_SOURCE / INT_ENABLE

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } spi_state_e;

  // Observation struct for checkers.
  typedef struct packed {
    spi_state_e  state;
    logic [2:0]  bit_cnt;
    logic [5:0]  addr;
    logic        sclk_lvl;
    logic        sdi_rise;
    logic        sdi_fall;
  } spi_dbg_t;

  // Registers that accept writes from the initiator.
  function automatic logic is_writable(input logic [5:0] a);
    return ((a >= ADDR_RW_LO) && (a <= ADDR_RW_HI) && (a != ADDR_RO_2B)) ||
           (a == ADDR_DATA_FORMAT) || (a == ADDR_SPARE0) || (a == ADDR_SPARE1);
  endfunction

  // Acceleration data registers (snapshot-backed, clear DATA_READY on read).
  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// ---------------------------------------------------------------------------
// spi_input_sync
//   Brings one asynchronous SPI pin into the clk domain and detects edges.
//   Ports:
//     clk     - system clock
//     rst     - synchronous active-low reset
//     din_i   - asynchronous pin
//     level_o - synchronized level (last synchronizer stage)
//     rise_o  - 1-clk pulse on a synchronized 0->1 transition
//     fall_o  - 1-clk pulse on a synchronized 1->0 transition
//   The edge pulses are visible after STAGES clocks and are acted upon by
//   the consumer on the following edge, giving STAGES+1 clk of latency.
//   STAGES must be at least 1.
// ---------------------------------------------------------------------------
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/gsensor_spi_responder.sv
// ---------------------------------------------------------------------------
// gsensor_spi_responder
//   Emulates the ADXL345 SPI register interface (mode 3, 4-wire or 3-wire)
//   so the accelerometer initiator can be exercised without the real part.
//   Ports:
//     clk, rst               - system clock, synchronous active-low reset
//     spi_cs_n, spi_sclk     - chip select and SPI clock from the initiator
//     spi_sdi                - MOSI (4-wire) / SDIO input (3-wire)
//     sdi_out, sdi_oe        - SDIO drive and its enable (3-wire reads)
//     sdo_out, sdo_oe        - MISO drive and its enable (4-wire reads)
//     sample_x/y/z           - signed 16-bit test samples
//     sample_valid           - 1-clk strobe: latch samples, set DATA_READY
//     int1                   - INT_SOURCE[7] & INT_ENABLE[7]
//     busy                   - synchronized chip select is low
//     dbg                    - FSM state and conditioned lines for checkers
//
//   Handshake: there is no valid/ready pair here; a transaction is framed by
//   cs low, bits are sampled on synchronized sclk rise and shifted out on
//   synchronized sclk fall. A completed data byte is acted upon in the clk
//   after its 8th rise (write commit, or load of the next read byte).
// ---------------------------------------------------------------------------
module gsensor_spi_responder
  import gsensor_pkg::*;
#(
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        sdi_out,
  output logic        sdi_oe,
  output logic        sdo_out,
  output logic        sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic        busy,
  output spi_dbg_t    dbg
);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .din_i   (spi_cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .din_i   (spi_sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk     (clk),
    .rst     (rst),
    .din_i   (spi_sdi),
    .level_o (sdi_lvl),
    .rise_o  (sdi_rise),
    .fall_o  (sdi_fall)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  spi_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_in_q;
  logic [7:0]  shift_out_q;
  logic [5:0]  addr_q;
  logic        mb_q;
  logic        rd_pend_q;   // load next read byte this clk
  logic        wr_pend_q;   // commit shift_in_q to addr_q this clk
  logic        out_bit_q;
  logic        sdi_oe_q;
  logic        sdo_oe_q;

  logic [7:0]  rw_q [0:63]; // only writable addresses are ever updated
  logic [47:0] hold_q;      // {Z, Y, X} latched on sample_valid
  logic [47:0] snap_q;      // {Z1,Z0,Y1,Y0,X1,X0} copied on cs fall
  logic        data_ready_q;

  logic [7:0]  cmd_byte;
  logic        fmt_3wire;
  logic [7:0]  rd_byte;
  logic [2:0]  data_idx;

  // Command byte including the bit arriving on this rise.
  assign cmd_byte  = {shift_in_q[6:0], sdi_lvl};
  assign fmt_3wire = rw_q[ADDR_DATA_FORMAT][FMT_SPI3_BIT];

  // 0x32..0x37 map to snapshot bytes 0..5.
  assign data_idx = addr_q[2:0] - 3'd2;

  always_comb begin
    rd_byte = 8'h00;
    if (addr_q == ADDR_DEVID) begin
      rd_byte = DEVID_VAL;
    end else if (addr_q == ADDR_INT_SOURCE) begin
      rd_byte = {data_ready_q, 7'b0};
    end else if (is_data_addr(addr_q)) begin
      rd_byte = snap_q[{data_idx, 3'b000} +: 8];
    end else if (is_writable(addr_q)) begin
      rd_byte = rw_q[addr_q];
    end
  end

  // -------------------------------------------------------------------------
  // Transaction FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      addr_q      <= 6'h00;
      mb_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      out_bit_q   <= 1'b0;
      sdi_oe_q    <= 1'b0;
      sdo_oe_q    <= 1'b0;
    end else begin
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;

      // Byte-boundary actions scheduled by the previous clk.
      if (rd_pend_q) begin
        shift_out_q <= rd_byte;
      end
      if ((rd_pend_q || wr_pend_q) && mb_q) begin
        addr_q <= addr_q + 6'd1;   // wraps 0x3F -> 0x00
      end

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= 3'd0;
          end
        end

        CMD: begin
          if (sclk_rise) begin
            shift_in_q <= cmd_byte;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_q <= cmd_byte[CMD_ADDR_MSB:0];
              mb_q   <= cmd_byte[CMD_MB_BIT];
              if (cmd_byte[CMD_RW_BIT]) begin
                state_q   <= RDATA;
                rd_pend_q <= 1'b1;
                sdi_oe_q  <= fmt_3wire;
                sdo_oe_q  <= ~fmt_3wire;
              end else begin
                state_q <= WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (sclk_fall) begin
            out_bit_q   <= shift_out_q[7];
            shift_out_q <= {shift_out_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rd_pend_q <= 1'b1;
            end
          end
        end

        WDATA: begin
          if (sclk_rise) begin
            shift_in_q <= {shift_in_q[6:0], sdi_lvl};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_pend_q <= 1'b1;
            end
          end
        end
      endcase

      // cs rise ends the transaction from any state; an incomplete byte
      // never raised wr_pend_q, so it is simply dropped.
      if (cs_rise) begin
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        out_bit_q <= 1'b0;
        sdi_oe_q  <= 1'b0;
        sdo_oe_q  <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file, sample holding, snapshot and DATA_READY
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        rw_q[i] <= 8'h00;
      end
      hold_q       <= 48'h0;
      snap_q       <= 48'h0;
      data_ready_q <= 1'b0;
    end else begin
      if (wr_pend_q && is_writable(addr_q)) begin
        rw_q[addr_q] <= shift_in_q;
      end
      // Snapshot uses the holding value from before any same-clk strobe.
      if ((state_q == IDLE) && cs_fall) begin
        snap_q <= hold_q;
      end
      if (sample_valid) begin
        hold_q <= {sample_z, sample_y, sample_x};
      end
      // Set has priority over the read-triggered clear.
      if (sample_valid) begin
        data_ready_q <= 1'b1;
      end else if (rd_pend_q && is_data_addr(addr_q)) begin
        data_ready_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sdi_out = out_bit_q;
  assign sdo_out = out_bit_q;
  assign sdi_oe  = sdi_oe_q;
  assign sdo_oe  = sdo_oe_q;
  assign int1    = data_ready_q & rw_q[ADDR_INT_ENABLE][INT_DATA_READY_BIT];
  assign busy    = ~cs_lvl;

  assign dbg.state    = state_q;
  assign dbg.bit_cnt  = bit_cnt_q;
  assign dbg.addr     = addr_q;
  assign dbg.sclk_lvl = sclk_lvl;
  assign dbg.sdi_rise = sdi_rise;
  assign dbg.sdi_fall = sdi_fall;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_gsensor_spi_responder
//   Drives SPI transactions at SCLK = clk/20 and compares every returned
//   byte, enable and status output against a transaction-level model of the
//   ADXL345 register map held in plain arrays.
// ---------------------------------------------------------------------------
module tb_gsensor_spi_responder;
  import gsensor_pkg::*;

  localparam int HALF = 10;  // clk cycles per SCLK half period

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        spi_cs_n, spi_sclk, spi_sdi;
  logic        sdi_out, sdi_oe, sdo_out, sdo_oe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic        int1, busy;
  spi_dbg_t    dbg;

  gsensor_spi_responder #(.DEVID_VAL(8'hE5), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_cs_n     (spi_cs_n),
    .spi_sclk     (spi_sclk),
    .spi_sdi      (spi_sdi),
    .sdi_out      (sdi_out),
    .sdi_oe       (sdi_oe),
    .sdo_out      (sdo_out),
    .sdo_oe       (sdo_oe),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .int1         (int1),
    .busy         (busy),
    .dbg          (dbg)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: register contents seen by the initiator
  // -------------------------------------------------------------------------
  logic [7:0]  m_reg [64];
  logic [47:0] m_hold;   // bytes X0,X1,Y0,Y1,Z0,Z1 from LSB upward
  logic [47:0] m_snap;
  logic        m_dr;

  function automatic bit m_writable(input int a);
    return (a >= 'h1D && a <= 'h2F && a != 'h2B) || a == 'h31 || a == 'h38 || a == 'h39;
  endfunction

  function automatic logic [7:0] m_value(input int a);
    if (a == 0) return 8'hE5;
    if (a == 'h30) return {m_dr, 7'b0};
    if (a >= 'h32 && a <= 'h37) return m_snap[(a - 'h32) * 8 +: 8];
    if (m_writable(a)) return m_reg[a];
    return 8'h00;
  endfunction

  // One read-byte load by the responder: value becomes the next byte shifted
  // out, and reading a data register consumes DATA_READY.
  task automatic m_load(input int a);
    exp_q.push_back(m_value(a));
    if (a >= 'h32 && a <= 'h37) m_dr = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  logic [7:0] tx_buf [16];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b1; spi_sdi = 1'b0;
    sample_valid = 1'b0; sample_x = '0; sample_y = '0; sample_z = '0;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(5);
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_hold = '0; m_snap = '0; m_dr = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    m_hold = {z, y, x};
    m_dr   = 1'b1;
  endtask

  // cmd: command byte; nbytes: data bytes; abort_bits > 0 cuts the last
  // write byte short; pulse_after >= 0 strobes a new sample after that byte.
  task automatic spi_txn(input logic [7:0] cmd, input int nbytes, input int abort_bits,
                         input int pulse_after, input logic [15:0] px,
                         input logic [15:0] py, input logic [15:0] pz);
    bit   is_rd, mb, three, bad;
    int   addr, nbits;
    logic [7:0] got, exp;
    is_rd = cmd[7]; mb = cmd[6]; addr = int'(cmd[5:0]);
    three = m_reg['h31][6];

    spi_cs_n = 1'b0;
    m_snap = m_hold;
    wait_clk(HALF);
    check("busy_hi", busy, 1);

    bad = 0;
    for (int i = 7; i >= 0; i--) begin
      spi_sclk = 1'b0; spi_sdi = cmd[i];
      wait_clk(HALF);
      if (sdo_oe || sdi_oe) bad = 1;
      spi_sclk = 1'b1;
      wait_clk(HALF);
    end
    check("cmd_oe", bad, 0);

    if (is_rd) begin
      m_load(addr);
      if (mb) addr = (addr + 1) % 64;
    end

    for (int b = 0; b < nbytes; b++) begin
      bad = 0;
      got = 8'h00;
      nbits = (abort_bits > 0 && b == nbytes - 1) ? abort_bits : 8;
      for (int i = 7; i >= 8 - nbits; i--) begin
        spi_sclk = 1'b0;
        spi_sdi  = is_rd ? 1'($urandom_range(0, 1)) : tx_buf[b][i];
        wait_clk(HALF);
        if (is_rd) begin
          got[i] = three ? sdi_out : sdo_out;
          if ({sdi_oe, sdo_oe} !== (three ? 2'b10 : 2'b01)) bad = 1;
        end else if (sdo_oe || sdi_oe) begin
          bad = 1;
        end
        spi_sclk = 1'b1;
        wait_clk(HALF);
      end
      if (is_rd) begin
        exp = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", b), got, exp);
        check("rd_oe", bad, 0);
        m_load(addr);
        if (mb) addr = (addr + 1) % 64;
      end else begin
        check("wr_oe", bad, 0);
        if (nbits == 8) begin
          if (m_writable(addr)) m_reg[addr] = tx_buf[b];
          if (mb) addr = (addr + 1) % 64;
        end
      end
      if (b == pulse_after) pulse_sample(px, py, pz);
    end

    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
    exp_q.delete();  // drop the byte prefetched after the last one
    check("idle_oe", {sdo_oe, sdi_oe}, 2'b00);
    check("busy_lo", busy, 0);
    check("int1", int1, m_dr & m_reg['h2E][7]);
  endtask

  task automatic rd(input logic [7:0] cmd, input int n);
    spi_txn(cmd, n, 0, -1, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic wr1(input logic [5:0] a, input logic [7:0] d);
    tx_buf[0] = d;
    spi_txn({2'b00, a}, 1, 0, -1, 16'h0, 16'h0, 16'h0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    do_reset();
    check("rst_sdo_oe", sdo_oe, 0);
    check("rst_sdi_oe", sdi_oe, 0);
    check("rst_sdo_out", sdo_out, 0);
    check("rst_sdi_out", sdi_out, 0);
    check("rst_int1", int1, 0);
    check("rst_busy", busy, 0);

    // DEVID in 4-wire mode.
    rd(8'h80, 1);

    // Switch to 3-wire and read DATA_FORMAT back on SDIO.
    wr1(6'h31, 8'h40);
    rd(8'hB1, 1);

    // Sample, interrupt enable, 6-byte burst.
    pulse_sample(16'hFF38, 16'h0064, 16'h0100);
    wr1(6'h2E, 8'h80);
    check("int1_set", int1, 1);
    rd(8'hF2, 6);
    check("int1_clr", int1, 0);
    rd(8'hB0, 1);

    // Address wrap 0x3E -> 0x00.
    rd(8'hFE, 3);

    // Aborted write and write to read-only DEVID.
    tx_buf[0] = 8'h08;
    spi_txn(8'h2D, 1, 5, -1, 16'h0, 16'h0, 16'h0);
    rd(8'hAD, 1);
    wr1(6'h00, 8'h12);
    rd(8'h80, 1);

    // Back to 4-wire; new sample mid-burst after X0.
    wr1(6'h31, 8'h00);
    spi_txn(8'hF2, 6, 0, 0, 16'h1234, 16'hABCD, 16'h8001);
    rd(8'hF2, 6);
    // Mid-burst sample with no data-register read afterwards.
    spi_txn(8'hF6, 2, 0, 0, 16'h0F0E, 16'h7FFF, 16'h8000);
    rd(8'hB0, 1);
    rd(8'hF2, 6);

    // Multibyte write across 0x38..0x39, then MB=0 repeat read.
    tx_buf[0] = 8'h5A; tx_buf[1] = 8'hC3;
    spi_txn(8'h78, 2, 0, -1, 16'h0, 16'h0, 16'h0);
    rd(8'hF8, 2);
    rd(8'hB9, 3);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] c;
      int n;
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) c[5:0] = 6'($urandom_range('h30, 'h39));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0)
        pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      spi_txn(c, n, 0, ($urandom_range(0, 4) == 0) ? 0 : -1,
              16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Reset in the middle of a read drops the output enables at once.
    wr1(6'h31, 8'h00);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 0; i--) begin
      spi_sclk = 1'b0; spi_sdi = (i == 7);
      wait_clk(HALF);
      spi_sclk = 1'b1;
      wait_clk(HALF);
    end
    check("mid_oe_on", sdo_oe, 1);
    rst = 1'b0;
    wait_clk(1);
    check("mid_rst_sdo_oe", sdo_oe, 0);
    check("mid_rst_sdi_oe", sdi_oe, 0);
    do_reset();
    rd(8'h80, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time bound for the whole run.
  initial begin
    #3000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
